// File: rtl/iob_eth_pkg.sv
// Shared constants, state encoding and CRC-32 byte step for the Ethernet MAC datapaths.
// Pure declarations; no latency and no flow control.
package iob_eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          MIN_FRAME     = 60;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_t;

  // Reflected CRC-32 advanced by one byte, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/iob_eth_crc32.sv
// Byte-wide reflected CRC-32 register; i_init loads CRC_INIT, i_en folds in i_dat.
// Result visible one cycle after i_en; no backpressure, i_init wins over i_en.
module iob_eth_crc32
  import iob_eth_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_dat,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_crc <= CRC_INIT;
    else if (i_init) r_crc <= CRC_INIT;
    else if (i_en)   r_crc <= crc32_byte(r_crc, i_dat);
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/iob_eth_tx_mac.sv
// Ethernet TX MAC: preamble/SFD, buffer bytes, optional zero pad and FCS, then IFG, on MII or GMII.
// TX_EN rises one cycle after an accepted send_i; no queueing, send_i is ignored unless ready_o.
module iob_eth_tx_mac
  import iob_eth_pkg::*;
#(
  parameter int PHY_W     = 4,
  parameter int BUF_AW    = 11,
  parameter int IFG_BYTES = 12
) (
  input  logic              TX_CLK,
  input  logic              tx_rst,
  input  logic              send_i,
  input  logic [BUF_AW-1:0] nbytes_i,
  input  logic              pad_i,
  input  logic              crc_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [BUF_AW-1:0] addr_o,
  input  logic [7:0]        data_i,
  output logic              TX_EN,
  output logic [PHY_W-1:0]  TX_DATA
);

  localparam int BEATS = 8 / PHY_W;
  localparam int CW    = BUF_AW + 1;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] PRE_LAST = CW'(7);
  localparam logic [CW-1:0] MIN_LEN  = CW'(MIN_FRAME);
  localparam logic [CW-1:0] PAD_LAST = CW'(MIN_FRAME - 1);
  localparam logic [CW-1:0] FCS_LAST = CW'(3);
  localparam logic [CW-1:0] IFG_LAST = CW'(IFG_BYTES * BEATS - 1);

  tx_state_t         r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_beat, w_beat_nxt;
  logic              r_done, w_done_nxt;
  logic [BUF_AW-1:0] r_nbytes, r_addr;
  logic              r_pad, r_crc;
  logic [CW-1:0]     w_nb;
  logic              w_accept, w_beat_last, w_addr_inc, w_crc_en;
  logic [7:0]        w_byte;
  logic [31:0]       w_crc, w_fcs;

  assign w_nb        = {1'b0, r_nbytes};
  assign w_accept    = (r_state == ST_IDLE) && send_i && (nbytes_i != '0);
  assign w_beat_last = (BEATS == 1) ? 1'b1 : r_beat;
  assign w_crc_en    = ((r_state == ST_DATA) || (r_state == ST_PAD)) && !r_beat;
  assign w_fcs       = ~w_crc;

  // Keep addr_o one read ahead so byte k sits on data_i at its first beat.
  assign w_addr_inc = (BEATS == 1)
      ? (((r_state == ST_PRE) && (r_cnt == PRE_LAST)) ||
         ((r_state == ST_DATA) && (r_cnt != w_nb - ONE)))
      : ((r_state == ST_DATA) && !r_beat);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_beat_nxt  = r_beat;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_PRE;
          w_cnt_nxt   = '0;
          w_beat_nxt  = 1'b0;
        end
      end
      ST_IFG: begin
        if (r_cnt == IFG_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + ONE;
        end
      end
      default: begin
        w_beat_nxt = (BEATS > 1) ? ~r_beat : 1'b0;
        if (w_beat_last) begin
          w_cnt_nxt = r_cnt + ONE;
          case (r_state)
            ST_PRE: begin
              if (r_cnt == PRE_LAST) begin
                w_state_nxt = ST_DATA;
                w_cnt_nxt   = '0;
              end
            end
            ST_DATA: begin
              // PAD keeps counting from nbytes so it stops at the 60-byte total.
              if (r_cnt == w_nb - ONE) begin
                if (r_pad && (w_nb < MIN_LEN)) begin
                  w_state_nxt = ST_PAD;
                end else begin
                  w_state_nxt = r_crc ? ST_FCS : ST_IFG;
                  w_cnt_nxt   = '0;
                end
              end
            end
            ST_PAD: begin
              if (r_cnt == PAD_LAST) begin
                w_state_nxt = r_crc ? ST_FCS : ST_IFG;
                w_cnt_nxt   = '0;
              end
            end
            ST_FCS: begin
              if (r_cnt == FCS_LAST) begin
                w_state_nxt = ST_IFG;
                w_cnt_nxt   = '0;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_state)
      ST_PRE:  w_byte = (r_cnt == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
      ST_DATA: w_byte = data_i;
      ST_FCS: begin
        case (r_cnt[1:0])
          2'd0:    w_byte = w_fcs[7:0];
          2'd1:    w_byte = w_fcs[15:8];
          2'd2:    w_byte = w_fcs[23:16];
          default: w_byte = w_fcs[31:24];
        endcase
      end
      default: w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge TX_CLK or posedge tx_rst) begin
    if (tx_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_beat   <= 1'b0;
      r_done   <= 1'b0;
      r_nbytes <= '0;
      r_pad    <= 1'b0;
      r_crc    <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_beat  <= w_beat_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_nbytes <= nbytes_i;
        r_pad    <= pad_i;
        r_crc    <= crc_i;
        r_addr   <= '0;
      end else if (w_addr_inc) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  iob_eth_crc32 u_crc (
    .i_clk  (TX_CLK),
    .i_rst  (tx_rst),
    .i_init (w_accept),
    .i_en   (w_crc_en),
    .i_dat  ((r_state == ST_DATA) ? data_i : 8'h00),
    .o_crc  (w_crc)
  );

  assign ready_o = (r_state == ST_IDLE);
  assign done_o  = r_done;
  assign addr_o  = r_addr;
  assign TX_EN   = (r_state == ST_PRE) || (r_state == ST_DATA) ||
                   (r_state == ST_PAD) || (r_state == ST_FCS);

  generate
    if (PHY_W == 8) begin : g_gmii
      assign TX_DATA = w_byte;
    end else begin : g_mii
      assign TX_DATA = r_beat ? w_byte[7:4] : w_byte[3:0];
    end
  endgenerate

endmodule

// File: tb/tb_iob_eth_tx_mac.sv
// Bench for iob_eth_tx_mac: one MII and one GMII instance checked against a frame-level byte model.
module tb_iob_eth_tx_mac;

  localparam int AW  = 11;
  localparam int IFG = 12;

  typedef logic [7:0] bq_t[$];

  logic TX_CLK = 1'b0;
  logic tx_rst = 1'b1;
  always #5 TX_CLK = ~TX_CLK;

  int cyc = 0;
  always @(posedge TX_CLK) cyc <= cyc + 1;

  logic          send   [2];
  logic [AW-1:0] nbytes [2];
  logic          pad    [2];
  logic          crc    [2];
  logic          ready  [2];
  logic          done   [2];
  logic [AW-1:0] addr   [2];
  logic [7:0]    dat    [2];
  logic          tx_en  [2];
  logic [3:0]    tx_data4;
  logic [7:0]    tx_data8;

  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge TX_CLK) begin
    dat[0] <= mem[addr[0]];
    dat[1] <= mem[addr[1]];
  end

  iob_eth_tx_mac #(.PHY_W(4), .BUF_AW(AW), .IFG_BYTES(IFG)) u_dut (
    .TX_CLK(TX_CLK), .tx_rst(tx_rst), .send_i(send[0]), .nbytes_i(nbytes[0]),
    .pad_i(pad[0]), .crc_i(crc[0]), .ready_o(ready[0]), .done_o(done[0]),
    .addr_o(addr[0]), .data_i(dat[0]), .TX_EN(tx_en[0]), .TX_DATA(tx_data4));

  iob_eth_tx_mac #(.PHY_W(8), .BUF_AW(AW), .IFG_BYTES(IFG)) u_dut_g (
    .TX_CLK(TX_CLK), .tx_rst(tx_rst), .send_i(send[1]), .nbytes_i(nbytes[1]),
    .pad_i(pad[1]), .crc_i(crc[1]), .ready_o(ready[1]), .done_o(done[1]),
    .addr_o(addr[1]), .data_i(dat[1]), .TX_EN(tx_en[1]), .TX_DATA(tx_data8));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: rebuild bytes from the PHY stream, record TX_EN lengths, gaps and IFG delays.
  logic [7:0] cap_q [2][$];
  int len_q [2][$];
  int gap_q [2][$];
  int dly_q [2][$];
  logic en_prev [2];
  int en_run [2];
  int fall_cyc [2];
  bit have_fall [2];
  int done_cnt [2];
  int addr_max [2];
  bit half;
  logic [3:0] lo;

  always @(negedge TX_CLK) begin
    for (int g = 0; g < 2; g++) begin
      if (tx_en[g] === 1'b1) begin
        if (!en_prev[g] && have_fall[g]) gap_q[g].push_back(cyc - fall_cyc[g]);
        en_run[g]++;
        if (g == 1) cap_q[1].push_back(tx_data8);
        else if (!half) begin lo = tx_data4; half = 1'b1; end
        else begin cap_q[0].push_back({tx_data4, lo}); half = 1'b0; end
      end else if (en_prev[g]) begin
        len_q[g].push_back(en_run[g]);
        en_run[g]    = 0;
        fall_cyc[g]  = cyc;
        have_fall[g] = 1'b1;
        if (g == 0) half = 1'b0;
      end
      if (done[g] === 1'b1) begin
        done_cnt[g]++;
        dly_q[g].push_back(cyc - fall_cyc[g]);
        chk("done_during_tx_en", {63'd0, tx_en[g]}, 64'd0);
        chk("ready_with_done", {63'd0, ready[g]}, 64'd1);
      end
      if (int'(addr[g]) > addr_max[g]) addr_max[g] = int'(addr[g]);
      en_prev[g] = (tx_en[g] === 1'b1);
    end
  end

  task automatic clr();
    for (int g = 0; g < 2; g++) begin
      cap_q[g].delete(); len_q[g].delete(); gap_q[g].delete(); dly_q[g].delete();
      en_run[g] = 0; have_fall[g] = 1'b0; addr_max[g] = 0;
    end
    half = 1'b0;
  endtask

  // Reference model: frame bytes as they must appear on the wire.
  function automatic logic [31:0] crc_ref(input bq_t body);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (body[i]) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ body[i][b]) c = (c >> 1) ^ 32'hEDB88320;
        else                   c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic exp_frame(input int n, input bit p, input bit c, output bq_t q);
    bq_t body;
    logic [31:0] fcs;
    q = {};
    body = {};
    for (int i = 0; i < 7; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int i = 0; i < n; i++) body.push_back(mem[i]);
    if (p) while (body.size() < 60) body.push_back(8'h00);
    fcs = crc_ref(body);
    foreach (body[i]) q.push_back(body[i]);
    if (c) for (int j = 0; j < 4; j++) q.push_back(fcs[8*j +: 8]);
  endtask

  task automatic start(input int g, input int n, input bit p, input bit c);
    int t = 0;
    while (ready[g] !== 1'b1 && t < 5000) begin @(posedge TX_CLK); #1; t++; end
    chk("start_ready", {63'd0, ready[g]}, 64'd1);
    nbytes[g] = AW'(n); pad[g] = p; crc[g] = c; send[g] = 1'b1;
    @(posedge TX_CLK); #1;
    send[g] = 1'b0;
    addr_max[g] = 0;
  endtask

  task automatic wait_done(input int g, input int base);
    int t = 0;
    while (done_cnt[g] <= base && t < 6000) begin @(posedge TX_CLK); #1; t++; end
    chk("done_timeout", {63'd0, done_cnt[g] > base}, 64'd1);
  endtask

  task automatic check_frame(input int g, input int n, input bit p, input bit c,
                             input string tag, output int en_len);
    bq_t q;
    int beats;
    int d;
    beats = (g == 0) ? 2 : 1;
    exp_frame(n, p, c, q);
    chk({tag, "_nbytes"}, 64'(cap_q[g].size()), 64'(q.size()));
    for (int i = 0; i < q.size() && i < cap_q[g].size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), {56'd0, cap_q[g][i]}, {56'd0, q[i]});
      if (cap_q[g][i] !== q[i]) break;
    end
    en_len = (len_q[g].size() > 0) ? len_q[g].pop_front() : -1;
    chk({tag, "_en_len"}, 64'(en_len), 64'(q.size() * beats));
    d = (dly_q[g].size() > 0) ? dly_q[g].pop_front() : -1;
    chk({tag, "_ifg"}, 64'(d), 64'(IFG * beats));
    cap_q[g].delete();
  endtask

  function automatic logic [31:0] fcs_at(input int g, input int off);
    if (cap_q[g].size() < off + 4) return 32'hxxxxxxxx;
    return {cap_q[g][off+3], cap_q[g][off+2], cap_q[g][off+1], cap_q[g][off]};
  endfunction

  task automatic load_vec();
    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int base, el, t, n;
    bit p, c;
    bq_t q;
    for (int g = 0; g < 2; g++) begin
      send[g] = 0; nbytes[g] = '0; pad[g] = 0; crc[g] = 0;
      en_prev[g] = 0; done_cnt[g] = 0;
    end
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    clr();

    repeat (3) @(posedge TX_CLK);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("rst_ready", {63'd0, ready[g]}, 64'd1);
      chk("rst_done", {63'd0, done[g]}, 64'd0);
      chk("rst_addr", 64'(addr[g]), 64'd0);
      chk("rst_tx_en", {63'd0, tx_en[g]}, 64'd0);
    end
    chk("rst_tx_data4", 64'(tx_data4), 64'd0);
    chk("rst_tx_data8", 64'(tx_data8), 64'd0);
    tx_rst = 1'b0;
    @(posedge TX_CLK); #1;

    // MII check-value vector
    load_vec(); clr();
    base = done_cnt[0];
    start(0, 9, 0, 1);
    wait_done(0, base);
    chk("mii_fcs", 64'(fcs_at(0, 17)), 64'hCBF43926);
    check_frame(0, 9, 0, 1, "mii_vec", el);
    chk("mii_vec_en42", 64'(el), 64'd42);

    // GMII, same vector
    clr();
    base = done_cnt[1];
    start(1, 9, 0, 1);
    wait_done(1, base);
    chk("gmii_fcs", 64'(fcs_at(1, 17)), 64'hCBF43926);
    check_frame(1, 9, 0, 1, "gmii_vec", el);
    chk("gmii_vec_en21", 64'(el), 64'd21);

    // MII short frame padded to 60 bytes
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    clr();
    base = done_cnt[0];
    start(0, 14, 1, 1);
    wait_done(0, base);
    chk("pad_addr_max", 64'(addr_max[0]), 64'd14);
    check_frame(0, 14, 1, 1, "pad14", el);
    chk("pad14_en144", 64'(el), 64'd144);

    // zero-length request is ignored
    clr();
    nbytes[0] = '0; send[0] = 1'b1;
    @(posedge TX_CLK); #1;
    send[0] = 1'b0;
    repeat (30) @(posedge TX_CLK);
    #1;
    chk("zero_len_ready", {63'd0, ready[0]}, 64'd1);
    chk("zero_len_no_frame", 64'(len_q[0].size() + cap_q[0].size()), 64'd0);

    // request while busy is ignored
    clr();
    base = done_cnt[0];
    start(0, 20, 0, 1);
    repeat (40) @(posedge TX_CLK);
    #1;
    nbytes[0] = AW'(5); send[0] = 1'b1;
    @(posedge TX_CLK); #1;
    send[0] = 1'b0;
    wait_done(0, base);
    check_frame(0, 20, 0, 1, "busy_req", el);
    repeat (200) @(posedge TX_CLK);
    #1;
    chk("busy_req_no_extra", 64'(len_q[0].size() + cap_q[0].size()), 64'd0);
    chk("busy_req_done_cnt", 64'(done_cnt[0] - base), 64'd1);

    // asynchronous reset in the middle of DATA
    load_vec(); clr();
    start(0, 9, 0, 1);
    repeat (24) @(posedge TX_CLK);
    #1;
    chk("mid_rst_was_tx", {63'd0, tx_en[0]}, 64'd1);
    #2 tx_rst = 1'b1;
    #1;
    chk("mid_rst_tx_en", {63'd0, tx_en[0]}, 64'd0);
    chk("mid_rst_tx_data", 64'(tx_data4), 64'd0);
    chk("mid_rst_ready", {63'd0, ready[0]}, 64'd1);
    chk("mid_rst_addr", 64'(addr[0]), 64'd0);
    @(posedge TX_CLK); #1;
    tx_rst = 1'b0;
    repeat (3) @(posedge TX_CLK);
    #1;
    clr();
    base = done_cnt[0];
    start(0, 9, 0, 1);
    wait_done(0, base);
    check_frame(0, 9, 0, 1, "post_rst", el);
    chk("post_rst_en42", 64'(el), 64'd42);

    // back-to-back with send_i held high
    clr();
    base = done_cnt[0];
    nbytes[0] = AW'(9); pad[0] = 0; crc[0] = 1; send[0] = 1'b1;
    t = 0;
    while (done_cnt[0] - base < 3 && t < 3000) begin @(negedge TX_CLK); #1; t++; end
    send[0] = 1'b0;
    repeat (100) @(posedge TX_CLK);
    #1;
    chk("b2b_done_cnt", 64'(done_cnt[0] - base), 64'd3);
    chk("b2b_frames", 64'(len_q[0].size()), 64'd3);
    chk("b2b_gaps", 64'(gap_q[0].size()), 64'd2);
    for (int i = 0; i < 2 && i < gap_q[0].size(); i++)
      chk($sformatf("b2b_gap%0d", i), 64'(gap_q[0][i]), 64'(IFG * 2 + 1));
    exp_frame(9, 0, 1, q);
    chk("b2b_nbytes", 64'(cap_q[0].size()), 64'(3 * q.size()));
    for (int i = 0; i < 3 * q.size() && i < cap_q[0].size(); i++) begin
      chk($sformatf("b2b_byte%0d", i), {56'd0, cap_q[0][i]}, {56'd0, q[i % q.size()]});
      if (cap_q[0][i] !== q[i % q.size()]) break;
    end

    // randomized frames on both PHY widths
    for (int it = 0; it < 12; it++) begin
      int g;
      g = $urandom_range(0, 1);
      n = $urandom_range(1, 80);
      p = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
      clr();
      base = done_cnt[g];
      start(g, n, p, c);
      wait_done(g, base);
      chk($sformatf("rand%0d_addr_max", it), 64'(addr_max[g]), 64'(n));
      check_frame(g, n, p, c, $sformatf("rand%0d", it), el);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
